// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared external R-type ALU: grant, execute, respond.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 win every tie instead of round-robin.
module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_instr,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_instr,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      alu_instr,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  input  logic [31:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       rr_ptr;
  logic       gnt;
  logic       gnt_id;
  logic       op_ok;

  assign fsm_state = state;

  // Handshakes: a request transfers in the cycle reqN_valid && reqN_ready (ready is
  // combinational, IDLE only); a response transfers in the cycle rsp_valid && rsp_ready.
  always_comb begin
    gnt = !rst && (state == IDLE) && (req0_valid || req1_valid);
`ifdef ALU_ARB_FIXED_PRIO_EN
    // rr_ptr is pinned at 0 here, so a tie always resolves to req0.
    gnt_id = req0_valid ? rr_ptr : 1'b1;
`else
    gnt_id = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
`endif
  end

  assign req0_ready = gnt && !gnt_id;
  assign req1_ready = gnt && gnt_id;

  always_comb begin
    op_ok = 1'b0;
    case ({alu_instr[30], alu_instr[14:12]})
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: op_ok = 1'b1;
      default:                                     op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_tag   <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_instr <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt) begin
            alu_instr <= gnt_id ? req1_instr : req0_instr;
            alu_in1   <= gnt_id ? req1_a     : req0_a;
            alu_in2   <= gnt_id ? req1_b     : req0_b;
            rsp_tag   <= gnt_id ? req1_tag   : req0_tag;
            rsp_id    <= gnt_id;
`ifdef ALU_ARB_FIXED_PRIO_EN
            rr_ptr    <= 1'b0;
`else
            rr_ptr    <= !gnt_id;
`endif
            state     <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported codes never leak whatever the shared ALU produced.
          rsp_data  <= op_ok ? alu_out : 32'd0;
          rsp_err   <= !op_ok;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a cycle-count transaction model.
// The bench's external ALU is a plain behavioural function of the ALU port values.
module tb_alu_arbiter;

  localparam int TAG_W = 4;
  localparam int EW    = 2 + TAG_W + 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_instr, req0_a, req0_b;
  logic [31:0]      req1_instr, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [31:0]      alu_instr, alu_in1, alu_in2, alu_out;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;
  logic [1:0]       fsm_state;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'hdeadbeef;
    endcase
  endfunction

  assign alu_out = alu_ref({alu_instr[30], alu_instr[14:12]}, alu_in1, alu_in2);

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_instr(alu_instr), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Transaction model: one op in flight, response due two cycles after acceptance.
  logic             m_pending = 1'b0;
  int               m_acc     = 0;
  int               cyc       = 0;
  logic             m_rr      = 1'b0;
  logic [31:0]      m_instr   = '0;
  logic [31:0]      m_a       = '0;
  logic [31:0]      m_b       = '0;
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    obs_q[$];
  int               gnt_q[$];

  function automatic logic [31:0] mk_instr(input logic [3:0] op);
    logic [31:0] w;
    w        = $urandom;
    w[30]    = op[3];
    w[14:12] = op[2:0];
    return w;
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] ops [10];
    ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
    if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
    return ops[$urandom_range(0, 9)];
  endfunction

  task automatic step(input logic r,
                      input logic v0, input logic [31:0] i0, input logic [31:0] a0, input logic [31:0] b0, input logic [TAG_W-1:0] t0,
                      input logic v1, input logic [31:0] i1, input logic [31:0] a1, input logic [31:0] b1, input logic [TAG_W-1:0] t1,
                      input logic rr);
    logic          exp_gnt, exp_id, exp_valid, e;
    logic [3:0]    op;
    logic [31:0]   d, ins, a, b;
    logic [TAG_W-1:0] tg;
    rst = r; rsp_ready = rr;
    req0_valid = v0; req0_instr = i0; req0_a = a0; req0_b = b0; req0_tag = t0;
    req1_valid = v1; req1_instr = i1; req1_a = a1; req1_b = b1; req1_tag = t1;
    #1;
    exp_gnt = !r && !m_pending && (v0 || v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_id = !v0;
`else
    exp_id = (v0 && v1) ? m_rr : v1;
`endif
    exp_valid = !r && m_pending && (cyc >= m_acc + 2);
    check("req0_ready", req0_ready, exp_gnt && !exp_id);
    check("req1_ready", req1_ready, exp_gnt && exp_id);
    if (!r) begin
      check("rsp_valid", rsp_valid, exp_valid);
      check("alu_instr", alu_instr, m_instr);
      check("alu_in1", alu_in1, m_a);
      check("alu_in2", alu_in2, m_b);
      if (exp_valid && rsp_valid && exp_q.size() > 0) begin
        check("rsp_fields", {rsp_id, rsp_err, rsp_tag, rsp_data}, exp_q[0]);
        if (rr) obs_q.push_back({rsp_id, rsp_err, rsp_tag, rsp_data});
      end
    end
    if (req0_ready) gnt_q.push_back(0);
    if (req1_ready) gnt_q.push_back(1);
    @(posedge clk);
    if (r) begin
      m_pending = 1'b0; exp_q.delete(); m_rr = 1'b0;
      m_instr = '0; m_a = '0; m_b = '0;
    end else if (exp_valid && rr) begin
      m_pending = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_gnt) begin
      ins = exp_id ? i1 : i0;
      a   = exp_id ? a1 : a0;
      b   = exp_id ? b1 : b0;
      tg  = exp_id ? t1 : t0;
      op  = {ins[30], ins[14:12]};
      if (op inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111}) begin
        d = alu_ref(op, a, b); e = 1'b0;
      end else begin
        d = 32'd0; e = 1'b1;
      end
      exp_q.push_back({exp_id, e, tg, d});
      m_pending = 1'b1; m_acc = cyc;
      m_instr = ins; m_a = a; m_b = b;
`ifdef ALU_ARB_FIXED_PRIO_EN
      m_rr = 1'b0;
`else
      m_rr = !exp_id;
`endif
    end
    cyc++;
    @(negedge clk);
  endtask

  // Invalid requesters carry random junk that must be ignored.
  task automatic idle(input logic rr);
    step(1'b0, 1'b0, $urandom, $urandom, $urandom, TAG_W'($urandom),
               1'b0, $urandom, $urandom, $urandom, TAG_W'($urandom), rr);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, $urandom, $urandom, $urandom, TAG_W'($urandom),
               1'b1, $urandom, $urandom, $urandom, TAG_W'($urandom), 1'b0);
    step(1'b1, 1'b0, $urandom, $urandom, $urandom, TAG_W'($urandom),
               1'b0, $urandom, $urandom, $urandom, TAG_W'($urandom), 1'b0);
  endtask

  task automatic check_obs(input string name, input int idx, input logic id, input logic err,
                           input logic [TAG_W-1:0] tag, input logic [31:0] data);
    logic [EW-1:0] o;
    if (idx < obs_q.size()) begin
      o = obs_q[idx];
      check({name, "_id"},   o[EW-1], id);
      check({name, "_err"},  o[EW-2], err);
      check({name, "_tag"},  o[32+TAG_W-1:32], tag);
      check({name, "_data"}, o[31:0], data);
    end else begin
      check({name, "_present"}, 0, 1);
    end
  endtask

  initial begin
    int ob, gb;
    rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id",    rsp_id, 0);
    check("rst_rsp_tag",   rsp_tag, 0);
    check("rst_rsp_data",  rsp_data, 0);
    check("rst_rsp_err",   rsp_err, 0);
    check("rst_alu_instr", alu_instr, 0);
    check("rst_alu_in1",   alu_in1, 0);
    check("rst_alu_in2",   alu_in2, 0);

    // Single add, latency checked by the model.
    ob = obs_q.size();
    step(1'b0, 1'b1, mk_instr(4'b0000), 32'd5, 32'd7, 4'd3, 1'b0, $urandom, $urandom, $urandom, 4'd0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check_obs("add", ob, 1'b0, 1'b0, 4'd3, 32'd12);

    // Both valid from reset: req0, req1, then req0 again.
    do_reset();
    ob = obs_q.size(); gb = gnt_q.size();
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, mk_instr(4'b1000), 32'd10, 32'd3, 4'd1,
                 1'b1, mk_instr(4'b0100), 32'hf0, 32'hff, 4'd2, 1'b1);
    idle(1'b1); idle(1'b1);
    check_obs("rr_first", ob, 1'b0, 1'b0, 4'd1, 32'd7);
    check_obs("rr_second", ob + 1, 1'b1, 1'b0, 4'd2, 32'h0f);
    check("rr_third_gnt", (gb + 2 < gnt_q.size()) ? gnt_q[gb + 2] : -1, 0);

    // Back-pressure: response held for 5 cycles with both requesters waiting.
    step(1'b0, 1'b1, mk_instr(4'b0110), 32'h1234, 32'h00f0, 4'd9, 1'b0, $urandom, $urandom, $urandom, 4'd0, 1'b0);
    idle(1'b0);
    gb = gnt_q.size();
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, mk_instr(4'b0000), 32'd1, 32'd2, 4'd4, 1'b1, mk_instr(4'b0111), 32'd3, 32'd6, 4'd5, 1'b0);
    check("hold_no_grant", gnt_q.size() - gb, 0);
    step(1'b0, 1'b1, mk_instr(4'b0000), 32'd1, 32'd2, 4'd4, 1'b1, mk_instr(4'b0111), 32'd3, 32'd6, 4'd5, 1'b1);
    step(1'b0, 1'b1, mk_instr(4'b0000), 32'd1, 32'd2, 4'd4, 1'b1, mk_instr(4'b0111), 32'd3, 32'd6, 4'd5, 1'b1);
    check("release_grant", gnt_q.size() - gb, 1);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Unsupported op code 1001 from req1.
    ob = obs_q.size();
    step(1'b0, 1'b0, $urandom, $urandom, $urandom, 4'd0, 1'b1, mk_instr(4'b1001), 32'd1, 32'd1, 4'd6, 1'b1);
    idle(1'b1); idle(1'b1);
    check_obs("bad_op", ob, 1'b1, 1'b1, 4'd6, 32'd0);

    // Reset during EXEC discards the op and restarts arbitration at req0.
    do_reset();
    ob = obs_q.size();
    step(1'b0, 1'b0, $urandom, $urandom, $urandom, 4'd0, 1'b1, mk_instr(4'b0000), 32'd8, 32'd9, 4'd7, 1'b1);
    step(1'b1, 1'b0, $urandom, $urandom, $urandom, 4'd0, 1'b0, $urandom, $urandom, $urandom, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("rst_discard", obs_q.size() - ob, 0);
    gb = gnt_q.size();
    step(1'b0, 1'b1, mk_instr(4'b0000), 32'd1, 32'd1, 4'd1, 1'b1, mk_instr(4'b0000), 32'd2, 32'd2, 4'd2, 1'b1);
    check("post_rst_gnt", (gb < gnt_q.size()) ? gnt_q[gb] : -1, 0);
    idle(1'b1); idle(1'b1); idle(1'b1);

`ifdef ALU_ARB_FIXED_PRIO_EN
    do_reset();
    gb = gnt_q.size();
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, mk_instr(rand_op()), $urandom, $urandom, TAG_W'($urandom),
                 1'b1, mk_instr(rand_op()), $urandom, $urandom, TAG_W'($urandom), 1'b1);
    check("fixed_cnt", gnt_q.size() - gb, 4);
    for (int i = 0; i < 4; i++)
      check("fixed_gnt", (gb + i < gnt_q.size()) ? gnt_q[gb + i] : -1, 0);
    idle(1'b1); idle(1'b1); idle(1'b1);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 6, mk_instr(rand_op()), $urandom, $urandom, TAG_W'($urandom),
           $urandom_range(0, 9) < 6, mk_instr(rand_op()), $urandom, $urandom, TAG_W'($urandom),
           $urandom_range(0, 9) < 7);
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of requester transaction tag.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) holds a pending ALU operation.
REQ-005 SHALL have ports reqN_ready  output  1  requester N's operation accepted this cycle.
REQ-006 SHALL have ports reqN_instr  input  32  R-type instruction word; op select = {instr[30], instr[14:12]}.
REQ-007 SHALL have ports reqN_a, reqN_b  input  32  rs1/rs2 operand values.
REQ-008 SHALL have ports reqN_tag  input  TAG_W  requester-private tag, returned unchanged.
REQ-009 SHALL have ports alu_instr, alu_in1, alu_in2  output  32  drive to the shared external R-type ALU.
REQ-010 SHALL have port alu_out  input  32  combinational result of the shared ALU.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have ports rsp_id (1), rsp_tag (TAG_W), rsp_data (32), rsp_err (1)  output  granted requester, its tag, result, unsupported-op flag.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one transaction in flight maximum.
REQ-015 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally that cycle only, capture instr/a/b/tag/id, move to EXEC; else stay.
REQ-016 reqN_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-017 Arbitration: single valid requester SHALL be granted; both valid SHALL grant rr_ptr; after any grant rr_ptr SHALL become the other requester.
REQ-018 alu_instr/alu_in1/alu_in2 SHALL always equal captured registers (hold last values in IDLE/RESP).
REQ-019 EXEC: SHALL register alu_out into rsp_data at end of the single EXEC cycle, move to RESP.
REQ-020 Supported op codes: 0000,1000,0001,0010,0011,0100,0101,1101,0110,0111; any other code SHALL give rsp_err=1 and rsp_data=0.
REQ-021 RESP: rsp_valid=1; rsp_id/tag/data/err SHALL stay stable until rsp_ready=1; on rsp_ready=1 SHALL clear rsp_valid and enter IDLE next cycle.
REQ-022 Latency: acceptance in cycle T SHALL yield rsp_valid in cycle T+2; peak throughput one operation per 3 cycles.
REQ-023 Requester inputs changing while not granted SHALL have no effect; reqN_valid dropped before grant SHALL be treated as no request.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_data=0, rsp_err=0, captured instr/a/b=0.
REQ-025 reqN_ready SHALL be 0 while rst=1.
REQ-026 Reset in EXEC or RESP SHALL discard the transaction; no response SHALL ever be issued for it.

Configuration
REQ-027 Macro ALU_ARB_FIXED_PRIO_EN defined: req0 SHALL win whenever both are valid; rr_ptr SHALL stay 0.
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-017.

Verification
REQ-029 After reset, req0 add (op 0000) a=5 b=7 tag=3 -> req0_ready cycle T, rsp_valid T+2 with data=12, id=0, tag=3, err=0.
REQ-030 Both valid from reset: req0 sub a=10 b=3, req1 xor a=0xF0 b=0xFF -> first rsp id=0 data=7, second rsp id=1 data=0x0F; third simultaneous request granted to req0.
REQ-031 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, reqN_ready=0, no new grant; release -> IDLE next cycle.
REQ-032 req1 instr with op code 1001, a=1 b=1 -> rsp_err=1, rsp_data=0, id=1.
REQ-033 rst pulsed during EXEC of req1 op -> no rsp_valid afterwards; next simultaneous request granted to req0.
REQ-034 With ALU_ARB_FIXED_PRIO_EN, both requesters valid continuously for 4 transactions -> all four grants to req0.
